// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo/delay effect stage.
// Sample width, buffer geometry, FSM encoding, delay decoding and saturation.
package echo_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic        [ADDR_W-1:0] addr_t;
    typedef logic        [ADDR_W:0]   count_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_MIX
    } state_t;

    // Delay in samples: (level+1) eighths of the buffer, 512..4096.
    function automatic count_t delay_of(input logic [2:0] level);
        count_t steps;
        steps = count_t'(level) + count_t'(1);
        return steps << (ADDR_W - 3);
    endfunction

    // Clamp a DATA_W+1 bit sum back into the DATA_W range.
    function automatic sample_t sat16(input logic signed [DATA_W:0] value);
        if (value[DATA_W] != value[DATA_W-1]) begin
            return value[DATA_W] ? sample_t'({1'b1, {(DATA_W-1){1'b0}}})
                                 : sample_t'({1'b0, {(DATA_W-1){1'b1}}});
        end
        return value[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module echo_delay_ram
    import echo_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/effect_echo.sv
// Echo/delay effect: one sample in flight through IDLE -> READ -> MIX, output 3 cycles after strobe.
// Build option: define ECHO_FEEDBACK_EN to write the mixed echo back into the buffer (regenerating repeats).
module effect_echo
    import echo_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_enable,
    input  logic [2:0]        i_level,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_overrun
);

    state_t  state_reg;
    state_t  state_next;

    sample_t x_reg;
    logic    enable_reg;
    count_t  delay_reg;
    addr_t   rd_addr_reg;
    addr_t   wr_ptr_reg;
    count_t  fill_cnt_reg;

    logic    accept;
    logic    ram_re;
    logic    mix;
    logic    overrun_hit;

    sample_t ram_q;
    sample_t echo_d;
    sample_t mix_data;
    sample_t wdata;
    count_t  delay_next;
    logic signed [DATA_W:0] echo_sum;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:  if (i_valid) state_next = S_READ;
            S_READ:  state_next = S_MIX;
            S_MIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        accept      = 1'b0;
        ram_re      = 1'b0;
        mix         = 1'b0;
        overrun_hit = 1'b0;
        unique case (state_reg)
            S_IDLE:  accept = i_valid;
            S_READ:  begin ram_re = 1'b1; overrun_hit = i_valid; end
            S_MIX:   begin mix    = 1'b1; overrun_hit = i_valid; end
            default: ;
        endcase
    end

    // Buffer slots older than the samples written so far read as silence.
    always_comb begin
        delay_next = delay_of(i_level);
        echo_d     = (fill_cnt_reg >= delay_reg) ? ram_q : '0;
        echo_sum   = (DATA_W+1)'(x_reg) + (DATA_W+1)'(echo_d >>> 1);
        mix_data   = enable_reg ? sat16(echo_sum) : x_reg;
    end

`ifdef ECHO_FEEDBACK_EN
    logic signed [DATA_W:0] fb_sum;

    always_comb begin
        fb_sum = (DATA_W+1)'(x_reg) + (DATA_W+1)'(echo_d >>> 2);
        wdata  = enable_reg ? sat16(fb_sum) : x_reg;
    end
`else
    assign wdata = x_reg;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_reg        <= '0;
            enable_reg   <= 1'b0;
            delay_reg    <= '0;
            rd_addr_reg  <= '0;
            wr_ptr_reg   <= '0;
            fill_cnt_reg <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_valid <= mix;
            if (overrun_hit) begin
                o_overrun <= 1'b1;
            end
            if (accept) begin
                x_reg       <= sample_t'(i_data);
                enable_reg  <= i_enable;
                delay_reg   <= delay_next;
                // Full-buffer delay wraps to wr_ptr itself, i.e. the oldest sample.
                rd_addr_reg <= wr_ptr_reg - delay_next[ADDR_W-1:0];
            end
            if (mix) begin
                o_data     <= mix_data;
                wr_ptr_reg <= wr_ptr_reg + addr_t'(1);
                if (fill_cnt_reg != count_t'(DEPTH)) begin
                    fill_cnt_reg <= fill_cnt_reg + count_t'(1);
                end
            end
        end
    end

    echo_delay_ram #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_ram (
        .clk   (i_clk),
        .we    (mix),
        .waddr (wr_ptr_reg),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (rd_addr_reg),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_effect_echo.sv
// Directed self-checking bench for effect_echo: impulse, saturation, bypass, overrun, reset, wrap.
// Expected values are hand-derived per scenario; ECHO_FEEDBACK_EN changes the regenerated impulse taps.
module tb_effect_echo;

    int total = 0;
    int bad   = 0;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              valid   = 1'b0;
    logic              enable  = 1'b0;
    logic [2:0]        level   = 3'd0;
    logic signed [15:0] din    = '0;
    logic signed [15:0] dout;
    logic              vout;
    logic              ovr;

    int outs [0:4999];
    int lats [0:4999];

    effect_echo dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid),
        .i_enable  (enable),
        .i_level   (level),
        .i_data    (din),
        .o_data    (dout),
        .o_valid   (vout),
        .o_overrun (ovr)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Strobe one sample and wait (bounded) for the matching output strobe.
    task automatic send(input logic signed [15:0] d, input logic en, input logic [2:0] lv,
                        output int q, output int lat);
        @(negedge clk);
        valid  = 1'b1;
        din    = d;
        enable = en;
        level  = lv;
        @(negedge clk);
        valid = 1'b0;
        lat   = 1;
        while (!vout && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        q = int'(dout);
        if (!vout) begin
            total++;
            bad++;
            $display("FAIL send_timeout: o_valid=%b required=1 within 8 cycles", vout);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({vout, ovr, dout} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b overrun=%b data=%0d required 0/0/0", vout, ovr, dout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({vout, ovr, dout} !== 18'd0) begin
            bad++;
            $display("FAIL after_reset_outputs: valid=%b overrun=%b data=%0d required 0/0/0", vout, ovr, dout);
        end
    endtask

    task automatic test_impulse();
        int q, lat, nz, badlat, exp1024, exp1536;
`ifdef ECHO_FEEDBACK_EN
        exp1024 = 125;
        exp1536 = 31;
`else
        exp1024 = 0;
        exp1536 = 0;
`endif
        do_reset();
        nz = 0;
        badlat = 0;
        for (int n = 0; n <= 1536; n++) begin
            send((n == 0) ? 16'sd1000 : 16'sd0, 1'b1, 3'd0, q, lat);
            outs[n] = q;
            if (lat != 3) badlat++;
        end
        for (int n = 1; n < 1536; n++) begin
            if (n != 512 && n != 1024 && outs[n] != 0) nz++;
        end
        @(negedge clk);
        total++;
        if (vout !== 1'b0) begin
            bad++;
            $display("FAIL impulse_pulse_width: o_valid=%b one cycle after strobe, required 0", vout);
        end
        total++;
        if (badlat != 0) begin
            bad++;
            $display("FAIL impulse_latency: %0d samples not at cycle 3, required 0", badlat);
        end
        total++;
        if (outs[0] != 1000) begin
            bad++;
            $display("FAIL impulse_direct: got %0d required 1000", outs[0]);
        end
        total++;
        if (nz != 0) begin
            bad++;
            $display("FAIL impulse_silence: %0d nonzero outputs, required 0", nz);
        end
        total++;
        if (outs[512] != 500) begin
            bad++;
            $display("FAIL impulse_echo512: got %0d required 500", outs[512]);
        end
        total++;
        if (outs[1024] != exp1024) begin
            bad++;
            $display("FAIL impulse_echo1024: got %0d required %0d", outs[1024], exp1024);
        end
        total++;
        if (outs[1536] != exp1536) begin
            bad++;
            $display("FAIL impulse_echo1536: got %0d required %0d", outs[1536], exp1536);
        end
    endtask

    task automatic test_saturation();
        int q, lat;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            send(16'sd30000, 1'b1, 3'd0, q, lat);
            outs[n] = q;
        end
        total++;
        if (outs[511] != 30000) begin
            bad++;
            $display("FAIL sat_pos_pre_echo: got %0d required 30000", outs[511]);
        end
        total++;
        if (outs[512] != 32767 || outs[599] != 32767) begin
            bad++;
            $display("FAIL sat_pos_clip: got %0d/%0d required 32767/32767", outs[512], outs[599]);
        end
        do_reset();
        for (int n = 0; n < 600; n++) begin
            send(-16'sd30000, 1'b1, 3'd0, q, lat);
            outs[n] = q;
        end
        total++;
        if (outs[0] != -30000) begin
            bad++;
            $display("FAIL sat_neg_direct: got %0d required -30000", outs[0]);
        end
        total++;
        if (outs[512] != -32768 || outs[599] != -32768) begin
            bad++;
            $display("FAIL sat_neg_clip: got %0d/%0d required -32768/-32768", outs[512], outs[599]);
        end
    endtask

    task automatic test_bypass();
        int q, lat, mism, badlat;
        do_reset();
        mism = 0;
        badlat = 0;
        for (int n = 0; n < 600; n++) begin
            send(16'(n * 8), 1'b0, 3'd0, q, lat);
            if (q != n * 8) mism++;
            if (lat != 3) badlat++;
        end
        total++;
        if (mism != 0 || badlat != 0) begin
            bad++;
            $display("FAIL bypass_passthrough: %0d data and %0d latency errors, required 0/0", mism, badlat);
        end
        send(16'sd4800, 1'b1, 3'd0, q, lat);
        total++;
        if (q != 5152) begin
            bad++;
            $display("FAIL bypass_enable_echo600: got %0d required 5152", q);
        end
        send(16'sd4808, 1'b1, 3'd0, q, lat);
        total++;
        if (q != 5164) begin
            bad++;
            $display("FAIL bypass_enable_echo601: got %0d required 5164", q);
        end
    endtask

    task automatic test_overrun();
        int pulses, first_at;
        logic signed [15:0] first_data;
        do_reset();
        @(negedge clk);
        valid = 1'b1; din = 16'sd111; enable = 1'b1; level = 3'd0;
        @(negedge clk);
        din = 16'sd222;
        @(negedge clk);
        valid = 1'b0;
        pulses = 0;
        first_at = 0;
        first_data = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (vout) begin
                if (pulses == 0) begin
                    first_at = k;
                    first_data = dout;
                end
                pulses++;
            end
        end
        total++;
        if (pulses != 1 || first_at != 1) begin
            bad++;
            $display("FAIL overrun_pulses: %0d pulses first at %0d, required 1 at 1", pulses, first_at);
        end
        total++;
        if (first_data != 16'sd111) begin
            bad++;
            $display("FAIL overrun_data: got %0d required 111", first_data);
        end
        total++;
        if (ovr !== 1'b1) begin
            bad++;
            $display("FAIL overrun_flag: got %b required 1", ovr);
        end
    endtask

    task automatic test_reset_mid_sample();
        int pulses, q, lat;
        @(negedge clk);
        valid = 1'b1; din = 16'sd777; enable = 1'b1; level = 3'd0;
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({vout, ovr, dout} !== 18'd0) begin
            bad++;
            $display("FAIL midreset_outputs: valid=%b overrun=%b data=%0d required 0/0/0", vout, ovr, dout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (vout) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL midreset_no_valid: %0d pulses required 0", pulses);
        end
        send(16'sd555, 1'b1, 3'd0, q, lat);
        total++;
        if (q != 555) begin
            bad++;
            $display("FAIL midreset_restart: got %0d required 555", q);
        end
    endtask

    task automatic test_level7_wrap();
        int q, lat, mism, expv;
        do_reset();
        mism = 0;
        for (int n = 0; n < 5000; n++) begin
            send(16'(n * 6), 1'b1, 3'd7, q, lat);
            outs[n] = q;
            expv = (n < 4096) ? n * 6 : n * 6 + ((n - 4096) * 6) / 2;
            if (q != expv) mism++;
        end
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL wrap_sequence: %0d mismatching outputs, required 0", mism);
        end
        total++;
        if (outs[4095] != 24570) begin
            bad++;
            $display("FAIL wrap_last_dry: got %0d required 24570", outs[4095]);
        end
        total++;
        if (outs[4096] != 24576 || outs[4999] != 32703) begin
            bad++;
            $display("FAIL wrap_echo: got %0d/%0d required 24576/32703", outs[4096], outs[4999]);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_saturation();
        test_bypass();
        test_overrun();
        test_reset_mid_sample();
        test_level7_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
